// File: rtl/modulo_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : modulo_updown_counter
// Purpose  : Cascadable up/down counter over [0..limit] with wrap/saturate
//            modes, parallel load, sticky boundary flag and bus output enable.
// Revision : 1.0 - initial release
// ============================================================================
module modulo_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cin,
  input  logic             load,
  input  logic             up,
  input  logic             sat,
  input  logic             oe,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_oe,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] C_RESET_VAL = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ZERO      = '0;

  if ((WIDTH < 2) || (WIDTH > 16)) begin : g_width_check
    $error("modulo_updown_counter: WIDTH out of range 2..16");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             count_ev;
  logic             at_bound;

  assign count_ev = en & cin & ~load;
  // q above limit counts as at-bound upward so an out-of-range load recovers.
  assign at_bound = up ? (q_q >= limit) : (q_q == C_ZERO);

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (load) begin
      q_d   = d;
      ovf_d = 1'b0;
    end else if (count_ev) begin
      if (at_bound) begin
        ovf_d = 1'b1;
        if (up) begin
          q_d = sat ? q_q : C_ZERO;
        end else begin
          q_d = sat ? C_ZERO : limit;
        end
      end else if (up) begin
        q_d = q_q + C_ONE;
      end else begin
        q_d = q_q - C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= C_RESET_VAL;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q    = q_q;
  assign ovf  = ovf_q;
  assign tc   = en & cin & at_bound;
  assign q_oe = {WIDTH{oe}};

endmodule
`default_nettype wire

// File: tb/tb_modulo_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulo_updown_counter
// Purpose  : Directed and randomized checks of modulo_updown_counter against
//            an integer reference model, plus a two-stage cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulo_updown_counter;
  localparam int W  = 8;
  localparam int RV = 7;

  logic         clk = 1'b0;
  logic         reset, en, cin, load, up, sat, oe;
  logic [W-1:0] d, limit;
  logic [W-1:0] q, q_oe;
  logic         tc, ovf;

  logic         c_rst, c_en, lo_tc, hi_tc, lo_ovf, hi_ovf;
  logic [W-1:0] c_lim, lo_q, hi_q, lo_oe, hi_oe;

  int checks   = 0;
  int failures = 0;

  int m_q;
  bit m_ovf;

  always #5 clk = ~clk;

  modulo_updown_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .cin(cin), .load(load), .up(up),
    .sat(sat), .oe(oe), .d(d), .limit(limit), .q(q), .q_oe(q_oe), .tc(tc),
    .ovf(ovf)
  );

  modulo_updown_counter #(.WIDTH(W)) u_lo (
    .clk(clk), .reset(c_rst), .en(c_en), .cin(1'b1), .load(1'b0), .up(1'b1),
    .sat(1'b0), .oe(1'b0), .d(8'h00), .limit(c_lim), .q(lo_q), .q_oe(lo_oe),
    .tc(lo_tc), .ovf(lo_ovf)
  );

  modulo_updown_counter #(.WIDTH(W)) u_hi (
    .clk(clk), .reset(c_rst), .en(c_en), .cin(lo_tc), .load(1'b0), .up(1'b1),
    .sat(1'b0), .oe(1'b1), .d(8'h00), .limit(c_lim), .q(hi_q), .q_oe(hi_oe),
    .tc(hi_tc), .ovf(hi_ovf)
  );

  // Reference behaviour written directly from the counting rules.
  function automatic void model_edge();
    int lim;
    lim = int'(limit);
    if (reset) begin
      m_q = RV; m_ovf = 0;
    end else if (load) begin
      m_q = int'(d); m_ovf = 0;
    end else if (en && cin) begin
      if (up) begin
        if (m_q < lim) m_q = m_q + 1;
        else begin m_ovf = 1; if (!sat) m_q = 0; end
      end else begin
        if (m_q > 0) m_q = m_q - 1;
        else begin m_ovf = 1; m_q = sat ? 0 : lim; end
      end
    end
  endfunction

  function automatic bit model_tc();
    return en && cin && (up ? (m_q >= int'(limit)) : (m_q == 0));
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; load = 1; d = 8'h55; en = 1; cin = 1; up = 1; sat = 0;
    limit = 8'(RV); oe = 0;
    tick();
    checks++; if (q !== 8'(RV)) begin failures++; $display("FAIL reset_q got=%0d exp=%0d", q, RV); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    #1;
    checks++; if (tc !== 1'b1) begin failures++; $display("FAIL reset_tc got=%0b exp=1", tc); end
    checks++; if (q_oe !== 8'h00) begin failures++; $display("FAIL oe_low got=%h exp=00", q_oe); end
    oe = 1; #1;
    checks++; if (q_oe !== 8'hFF) begin failures++; $display("FAIL oe_high got=%h exp=ff", q_oe); end
    en = 0; #1;
    checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc_en0 got=%0b exp=0", tc); end
  endtask

  task automatic test_wrap_up();
    reset = 0; load = 1; d = 0; limit = 9; en = 1; cin = 1; up = 1; sat = 0;
    tick();
    load = 0;
    for (int k = 0; k <= 11; k++) begin
      #1;
      checks++; if (q !== 8'(k % 10)) begin failures++; $display("FAIL up_q step=%0d got=%0d exp=%0d", k, q, k % 10); end
      checks++; if (tc !== ((k % 10) == 9)) begin failures++; $display("FAIL up_tc step=%0d got=%0b exp=%0b", k, tc, (k % 10) == 9); end
      checks++; if (ovf !== (k >= 10)) begin failures++; $display("FAIL up_ovf step=%0d got=%0b exp=%0b", k, ovf, k >= 10); end
      tick();
    end
  endtask

  task automatic test_wrap_down();
    load = 1; d = 0; limit = 9; up = 0; sat = 0;
    tick();
    load = 0;
    for (int k = 0; k <= 11; k++) begin
      #1;
      checks++; if (q !== 8'((10 - k % 10) % 10)) begin failures++; $display("FAIL down_q step=%0d got=%0d exp=%0d", k, q, (10 - k % 10) % 10); end
      checks++; if (tc !== (q == 0)) begin failures++; $display("FAIL down_tc step=%0d got=%0b q=%0d", k, tc, q); end
      tick();
    end
  endtask

  task automatic test_saturate();
    int exp_seq[4] = '{199, 200, 200, 200};
    load = 1; d = 198; limit = 200; up = 1; sat = 1;
    tick();
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sat_load_ovf got=%0b exp=0", ovf); end
    load = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (q !== 8'(exp_seq[k])) begin failures++; $display("FAIL sat_q edge=%0d got=%0d exp=%0d", k, q, exp_seq[k]); end
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", ovf); end
    checks++; if (tc !== 1'b1) begin failures++; $display("FAIL sat_tc got=%0b exp=1", tc); end
  endtask

  task automatic test_load_above_limit();
    load = 1; d = 250; limit = 100; up = 1; sat = 0;
    tick();
    checks++; if (q !== 8'd250) begin failures++; $display("FAIL above_load got=%0d exp=250", q); end
    load = 0;
    tick();
    checks++; if (q !== 8'd0) begin failures++; $display("FAIL above_wrap got=%0d exp=0", q); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL above_ovf got=%0b exp=1", ovf); end
    up = 0; load = 1; d = 3; #1;
    checks++; if (tc !== 1'b1) begin failures++; $display("FAIL load_tc got=%0b exp=1", tc); end
    tick();
    checks++; if (q !== 8'd3 || ovf !== 1'b0) begin failures++; $display("FAIL load_wins got q=%0d ovf=%0b exp q=3 ovf=0", q, ovf); end
  endtask

  task automatic test_limit_zero();
    load = 1; d = 0; limit = 0;
    tick();
    load = 0;
    for (int k = 0; k < 8; k++) begin
      up = k[0]; sat = k[1]; en = 1; cin = !k[2]; #1;
      checks++; if (tc !== cin) begin failures++; $display("FAIL lim0_tc step=%0d got=%0b exp=%0b", k, tc, cin); end
      tick();
      checks++; if (q !== 8'd0) begin failures++; $display("FAIL lim0_q step=%0d got=%0d exp=0", k, q); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      cin   = ($urandom_range(0, 3) != 0);
      up    = $urandom_range(0, 1);
      sat   = ($urandom_range(0, 3) == 0);
      oe    = $urandom_range(0, 1);
      d     = 8'($urandom_range(0, 255));
      limit = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      #1;
      checks++; if (tc !== model_tc()) begin failures++; $display("FAIL rnd_tc cyc=%0d got=%0b exp=%0b", k, tc, model_tc()); end
      checks++; if (q_oe !== {W{oe}}) begin failures++; $display("FAIL rnd_qoe cyc=%0d got=%h oe=%0b", k, q_oe, oe); end
      tick();
      checks++; if (q !== 8'(m_q)) begin failures++; $display("FAIL rnd_q cyc=%0d got=%0d exp=%0d", k, q, m_q); end
      checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", k, ovf, m_ovf); end
    end
    reset = 0; load = 0;
  endtask

  task automatic test_cascade();
    c_lim = 9; c_en = 1; c_rst = 1;
    @(posedge clk); #1;
    c_rst = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 37) begin
        checks++; if (lo_q !== 8'd7 || hi_q !== 8'd3) begin failures++; $display("FAIL casc_mid got lo=%0d hi=%0d exp lo=7 hi=3", lo_q, hi_q); end
        checks++; if (hi_ovf !== 1'b0) begin failures++; $display("FAIL casc_mid_ovf got=%0b exp=0", hi_ovf); end
      end
    end
    checks++; if (lo_q !== 8'd0 || hi_q !== 8'd0) begin failures++; $display("FAIL casc_end got lo=%0d hi=%0d exp 0/0", lo_q, hi_q); end
    checks++; if (hi_ovf !== 1'b1) begin failures++; $display("FAIL casc_ovf got=%0b exp=1", hi_ovf); end
  endtask

  initial begin
    reset = 1; en = 0; cin = 0; load = 0; up = 1; sat = 0; oe = 0;
    d = 0; limit = 0; m_q = 0; m_ovf = 0;
    c_rst = 1; c_en = 0; c_lim = 9;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_above_limit();
    test_limit_zero();
    test_random();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
